// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the digit display path.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  localparam int   NDIG_DEF = 5;
  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_HEX = 1'b1;
  localparam int   ITER_DEC = 16;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bank_to_digits.sv
// Splits a 16-bit word into display digits (decimal via double-dabble, or hex nibbles).
// BANK_TO_DIGITS_SIGNED_EN treats decimal input as two's complement and drives neg.
module bank_to_digits
  import calc_disp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = NDIG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   digit_en,
  output logic              neg
);

  localparam int CNTW = $clog2(ITER_DEC);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q;
  logic [4*NDIG-1:0] bcd_q;
  logic [4*NDIG-1:0] bcd_adj;
  logic [CNTW-1:0]   cnt_q;
  logic              mode_q;
  logic              neg_pend_q;
  logic              busy_q;
  logic              done_q;
  logic [4*NDIG-1:0] digits_q;
  logic [NDIG-1:0]   en_q;
  logic              neg_q;

  logic              cap_neg;
  logic [WIDTH-1:0]  cap_bin;
  logic [4*NDIG-1:0] result;
  logic [NDIG-1:0]   blank;

`ifdef BANK_TO_DIGITS_SIGNED_EN
  // Two's-complement negation wraps 0x8000 onto itself, which read unsigned is 32768.
  assign cap_neg = (mode == MODE_DEC) && value[WIDTH-1];
  assign cap_bin = cap_neg ? (~value + 1'b1) : value;
`else
  assign cap_neg = 1'b0;
  assign cap_bin = value;
`endif

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign result = (mode_q == MODE_HEX) ? {{(4*NDIG-WIDTH){1'b0}}, bin_q} : bcd_q;

  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      seen     = seen | (|result[4*i +: 4]);
      blank[i] = seen;
    end
    blank[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FINISH spends one cycle publishing results (done high) and one retiring to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (mode == MODE_HEX) ? FINISH : SHIFT;
      SHIFT:   if (cnt_q == CNTW'(ITER_DEC - 1)) state_d = FINISH;
      FINISH:  if (done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= MODE_DEC;
      neg_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '0;
      en_q       <= '0;
      neg_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q      <= cap_bin;
            bcd_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= mode;
            neg_pend_q <= cap_neg;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[4*NDIG-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 1'b1;
        end
        FINISH: begin
          if (!done_q) begin
            digits_q <= result;
            en_q     <= blank;
            neg_q    <= neg_pend_q;
            done_q   <= 1'b1;
          end else begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digits   = digits_q;
  assign digit_en = en_q;
  assign neg      = neg_q;

endmodule

// File: tb/tb_bank_to_digits.sv
// Directed self-checking bench for bank_to_digits; expectations follow BANK_TO_DIGITS_SIGNED_EN.
module tb_bank_to_digits;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] value = '0;
  logic        busy, done, neg;
  logic [19:0] digits;
  logic [4:0]  digit_en;

  int checks = 0;
  int errors = 0;

  bank_to_digits #(.WIDTH(16), .NDIG(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .digit_en (digit_en),
    .neg      (neg)
  );

  always #5 clk = ~clk;

`ifdef BANK_TO_DIGITS_SIGNED_EN
  localparam logic [19:0] EXP_FFFF_DIG = 20'h00001;
  localparam logic [4:0]  EXP_FFFF_EN  = 5'b00001;
  localparam logic        EXP_FFFF_NEG = 1'b1;
  localparam logic        EXP_8000_NEG = 1'b1;
`else
  localparam logic [19:0] EXP_FFFF_DIG = 20'h65535;
  localparam logic [4:0]  EXP_FFFF_EN  = 5'b11111;
  localparam logic        EXP_FFFF_NEG = 1'b0;
  localparam logic        EXP_8000_NEG = 1'b0;
`endif

  // Starts one conversion and watches 40 edges, recording done timing, results and busy.
  task automatic convert(input logic [15:0] v, input logic md,
                         input int extra_at, input logic [15:0] extra_v,
                         output int done_at, output int done_cnt,
                         output logic [19:0] dig, output logic [4:0] en,
                         output logic ng, output logic [40:0] busy_seen);
    done_at   = -1;
    done_cnt  = 0;
    dig       = '1;
    en        = '1;
    ng        = 1'b1;
    busy_seen = '0;
    value = v;
    mode  = md;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    value = 16'h5555;
    mode  = ~md;
    for (int n = 1; n <= 40; n++) begin
      if (n == extra_at) begin
        start = 1'b1;
        value = extra_v;
      end
      @(posedge clk); #1;
      start = 1'b0;
      busy_seen[n] = busy;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          dig     = digits;
          en      = digit_en;
          ng      = neg;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, digits, digit_en, neg} !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected 0", {busy, done, digits, digit_en, neg});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  localparam logic [15:0] DEC_V   [4] = '{16'd12345, 16'd0, 16'd42, 16'hFFFF};
  localparam logic [19:0] DEC_DIG [4] = '{20'h12345, 20'h00000, 20'h00042, EXP_FFFF_DIG};
  localparam logic [4:0]  DEC_EN  [4] = '{5'b11111, 5'b00001, 5'b00011, EXP_FFFF_EN};
  localparam logic        DEC_NEG [4] = '{1'b0, 1'b0, 1'b0, EXP_FFFF_NEG};

  task automatic test_decimal();
    int da, dc;
    logic [19:0] dg;
    logic [4:0] en;
    logic ng;
    logic [40:0] bs;
    for (int t = 0; t < 4; t++) begin
      convert(DEC_V[t], 1'b0, -1, 16'h0, da, dc, dg, en, ng, bs);
      checks++;
      if (da != 17 || dc != 1) begin
        errors++;
        $display("[TB] FAIL dec_done_%0d: got edge %0d count %0d expected edge 17 count 1", t, da, dc);
      end
      checks++;
      if (dg !== DEC_DIG[t] || en !== DEC_EN[t] || ng !== DEC_NEG[t]) begin
        errors++;
        $display("[TB] FAIL dec_result_%0d: got %h/%b/%b expected %h/%b/%b",
                 t, dg, en, ng, DEC_DIG[t], DEC_EN[t], DEC_NEG[t]);
      end
      if (t == 0) begin
        checks++;
        if (bs[1] !== 1'b1 || bs[17] !== 1'b1 || bs[18] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL dec_busy: got k+1=%b k+17=%b k+18=%b expected 1 1 0", bs[1], bs[17], bs[18]);
        end
        checks++;
        if (digits !== 20'h12345 || digit_en !== 5'b11111) begin
          errors++;
          $display("[TB] FAIL dec_hold: got %h/%b expected 12345/11111", digits, digit_en);
        end
      end
    end
  endtask

  task automatic test_hex();
    int da, dc;
    logic [19:0] dg;
    logic [4:0] en;
    logic ng;
    logic [40:0] bs;
    convert(16'hBEEF, 1'b1, -1, 16'h0, da, dc, dg, en, ng, bs);
    checks++;
    if (da != 1 || dc != 1) begin
      errors++;
      $display("[TB] FAIL hex_done: got edge %0d count %0d expected edge 1 count 1", da, dc);
    end
    checks++;
    if (dg !== 20'h0BEEF || en !== 5'b01111 || ng !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hex_beef: got %h/%b/%b expected 0beef/01111/0", dg, en, ng);
    end
    checks++;
    if (bs[1] !== 1'b1 || bs[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hex_busy: got k+1=%b k+2=%b expected 1 0", bs[1], bs[2]);
    end
    convert(16'h000A, 1'b1, -1, 16'h0, da, dc, dg, en, ng, bs);
    checks++;
    if (da != 1 || dg !== 20'h0000A || en !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL hex_000a: got edge %0d %h/%b expected edge 1 0000a/00001", da, dg, en);
    end
  endtask

  task automatic test_busy_ignore();
    int da, dc;
    logic [19:0] dg;
    logic [4:0] en;
    logic ng;
    logic [40:0] bs;
    convert(16'd12345, 1'b0, 5, 16'd7, da, dc, dg, en, ng, bs);
    checks++;
    if (da != 17 || dc != 1 || dg !== 20'h12345 || en !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL busy_ignore: got edge %0d count %0d %h/%b expected edge 17 count 1 12345/11111",
               da, dc, dg, en);
    end
  endtask

  // Start held across the done-deassert edge must only be taken one edge later.
  task automatic test_back_to_back();
    int first_done;
    int second_done;
    first_done  = -1;
    second_done = -1;
    value = 16'd5;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 18) begin
        start = 1'b1;
        value = 16'h0007;
        mode  = 1'b1;
      end
      if (n == 20) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (first_done < 0) first_done = n;
        else if (second_done < 0) second_done = n;
      end
    end
    start = 1'b0;
    checks++;
    if (first_done != 17 || second_done != 20) begin
      errors++;
      $display("[TB] FAIL back_to_back: got done edges %0d,%0d expected 17,20", first_done, second_done);
    end
    checks++;
    if (digits !== 20'h00007 || digit_en !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL back_to_back_result: got %h/%b expected 00007/00001", digits, digit_en);
    end
  endtask

  task automatic test_reset_mid();
    int dcount;
    int da, dc;
    logic [19:0] dg;
    logic [4:0] en;
    logic ng;
    logic [40:0] bs;
    dcount = 0;
    value = 16'd12345;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, digits, digit_en, neg} !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %h expected 0", {busy, done, digits, digit_en, neg});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got done count %0d busy %b expected 0 0", dcount, busy);
    end
    convert(16'd99, 1'b0, -1, 16'h0, da, dc, dg, en, ng, bs);
    checks++;
    if (da != 17 || dg !== 20'h00099 || en !== 5'b00011) begin
      errors++;
      $display("[TB] FAIL reset_restart: got edge %0d %h/%b expected edge 17 00099/00011", da, dg, en);
    end
  endtask

  task automatic test_signed();
    int da, dc;
    logic [19:0] dg;
    logic [4:0] en;
    logic ng;
    logic [40:0] bs;
    convert(16'h8000, 1'b0, -1, 16'h0, da, dc, dg, en, ng, bs);
    checks++;
    if (da != 17 || dg !== 20'h32768 || en !== 5'b11111 || ng !== EXP_8000_NEG) begin
      errors++;
      $display("[TB] FAIL signed_8000: got edge %0d %h/%b/%b expected edge 17 32768/11111/%b",
               da, dg, en, ng, EXP_8000_NEG);
    end
    convert(16'h7FFF, 1'b0, -1, 16'h0, da, dc, dg, en, ng, bs);
    checks++;
    if (dg !== 20'h32767 || en !== 5'b11111 || ng !== 1'b0) begin
      errors++;
      $display("[TB] FAIL signed_7fff: got %h/%b/%b expected 32767/11111/0", dg, en, ng);
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_to_digits.md
Name: bank_to_digits

Overview:
- Output-side counterpart of the keypad/cursor entry path: takes the 16-bit operand/result word and splits it into display digits.
- Decimal mode: iterative double-dabble binary-to-BCD conversion. Hex mode: nibble split.
- Adds leading-zero blanking and a start/busy/done handshake.
- Sits between the calculator datapath/state mux output and the 7-segment/VGA digit renderers.

Parameters:
- WIDTH, 16, input word width; only 16 is supported and verified.
- NDIG, 5, output digit count; must be >= 5 for WIDTH=16.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  conversion request, sampled only in IDLE
- mode  in  1  0 = decimal, 1 = hexadecimal
- value  in  16  word to convert, captured on the accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when digits/digit_en are updated
- digits  out  4*NDIG  nibble i = digit i, i=0 is the LSD
- digit_en  out  NDIG  bit i = 1 means digit i is displayed (leading-zero blanking)
- neg  out  1  sign flag, see Optional Feature

Behaviour:
- Reset (async, any state): FSM -> IDLE. busy=0, done=0, digits=0, digit_en=0, neg=0. Internal shift/BCD registers cleared.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE, start=1 at edge k:
  - Capture value and mode. Clear the BCD accumulator. iteration counter = 0. busy=1.
  - mode=0 -> SHIFT. mode=1 -> FINISH.
- SHIFT, one iteration per cycle:
  - Every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
  - After iteration 16 (counter == 15) -> FINISH.
  - Edges k+1..k+16.
- FINISH, at its entry edge:
  - digits and digit_en are written and done rises, so they become valid at the same edge.
  - Decimal: done rises at edge k+17. Hex: done rises at edge k+1.
  - Next edge: done=0, busy=0, FSM -> IDLE.
  - A start sampled on the done-deassert edge is ignored. The earliest accepted restart is the edge after that.
- Hex mode: digit i = value[4i+3:4i] for i=0..3. Digit 4 = 0 with digit_en[4]=0.
- Blanking:
  - digit_en[0] is always 1.
  - digit_en[i] (i>0) = 1 iff any digit j >= i is nonzero.
  - Value 0 therefore shows a single "0".
- digits/digit_en/neg hold their value between done pulses and are never partially updated.
- start while busy: ignored, no queueing. value/mode changes after capture have no effect.
- Reset mid-conversion: the conversion is aborted, outputs go to reset values, and no done is produced.
- Arithmetic: the BCD accumulator is 4*NDIG bits; 65535 needs 5 digits, so no overflow is possible.

Optional Feature:
- Macro: BANK_TO_DIGITS_SIGNED_EN.
- Defined:
  - In decimal mode, value is two's complement.
  - If value[15]=1: convert the magnitude (-value, 17-bit safe so 0x8000 -> 32768) and set neg=1 at done.
  - Otherwise neg=0.
  - Hex mode: neg=0 and raw nibbles are shown.
- Not defined:
  - value is unsigned in both modes.
  - neg is tied to 0; the port is still present.

Decomposition:
- Package calc_disp_pkg:
  - state enum (IDLE/SHIFT/FINISH)
  - constants NDIG_DEF=5, MODE_DEC=1'b0, MODE_HEX=1'b1, ITER_DEC=16
- Sub-module bcd_add3: combinational 4-bit "if >= 5 add 3" correction, instantiated NDIG times in the SHIFT datapath.

Test Plan:
- Decimal 12345 (0x3039), start at edge k -> done pulse at k+17 only. digits=0x12345, digit_en=5'b11111, busy high k+1..k+17.
- Decimal 0 -> digits=0x00000, digit_en=5'b00001. Decimal 65535 -> digits=0x65535, digit_en=5'b11111.
- Hex 0xBEEF, mode=1 -> done at k+1. digits=0x0BEEF, digit_en=5'b01111. Hex 0x000A -> digit_en=5'b00001.
- start pulsed again at k+5 with value 7 during a decimal 12345 conversion -> ignored, result still 0x12345. Decimal 42 -> digits=0x00042, digit_en=5'b00011.
- rst asserted asynchronously mid-edge during iteration 8 -> busy, done, digits, digit_en, neg all 0 immediately, no done pulse. Next start with decimal 99 -> 0x00099 at start+17.
- With BANK_TO_DIGITS_SIGNED_EN, decimal:
  - 0xFFFF -> neg=1, digits=0x00001, digit_en=5'b00001.
  - 0x8000 -> neg=1, digits=0x32768.
  - 0x7FFF -> neg=0, digits=0x32767.
- Without the macro, decimal 0xFFFF -> neg=0, digits=0x65535.
